// File: rtl/permutation_controller.sv
// ---------------------------------------------------------------------------
// permutation_controller
//
// Sequencing controller for the Ascon-128 permutation. Holds the 320-bit
// state register and the 4-bit round counter, drives the external
// combinational single-round datapath once per clock, and runs either p^a
// (NB_ROUNDS_A rounds, mode_i = 0) or p^b (NB_ROUNDS_B rounds, mode_i = 1).
// Rounds always end at index 11, so a request for n rounds starts the
// counter at 12 - n.
//
// State layout: the 5x64 state is flattened to 320 bits with word i at
// bits [64*i +: 64] (word 0 in the least significant 64 bits).
//
// Ports:
//   clock_i       in   system clock, rising edge
//   reset_i       in   synchronous active-high reset, priority over start_i
//   start_i       in   permutation request, accepted only while ready_o = 1
//   mode_i        in   0 = p^a, 1 = p^b, sampled with start_i
//   state_i       in   initial state, sampled with start_i
//   ready_o       out  high while idle
//   round_o       out  round index for the datapath constant addition
//   perm_state_o  out  current state register, feeds the round datapath
//   perm_state_i  in   one-round result from the datapath
//   state_o       out  permutation result, valid with done_o, held until
//                      the next accept
//   done_o        out  one-cycle pulse, result valid
// ---------------------------------------------------------------------------
module permutation_controller #(
    parameter int NB_ROUNDS_A = 12,
    parameter int NB_ROUNDS_B = 6
) (
    input  logic         clock_i,
    input  logic         reset_i,
    input  logic         start_i,
    input  logic         mode_i,
    input  logic [319:0] state_i,
    output logic         ready_o,
    output logic [3:0]   round_o,
    output logic [319:0] perm_state_o,
    input  logic [319:0] perm_state_i,
    output logic [319:0] state_o,
    output logic         done_o
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [3:0] LAST_ROUND   = 4'd11;
    localparam logic [3:0] FIRST_ROUND_A = 4'(12 - NB_ROUNDS_A);
    localparam logic [3:0] FIRST_ROUND_B = 4'(12 - NB_ROUNDS_B);

    logic [1:0]   fsm_r;
    logic [1:0]   fsm_next_s;
    logic [3:0]   round_cnt_r;
    logic [3:0]   round_next_s;
    logic [319:0] state_r;
    logic [319:0] state_next_s;
    logic         ready_r;
    logic         done_r;

    // Next-state, round counter and state register update selection
    always_comb begin
        fsm_next_s   = fsm_r;
        round_next_s = round_cnt_r;
        state_next_s = state_r;
        case (fsm_r)
            ST_IDLE: begin
                if (start_i) begin
                    state_next_s = state_i;
                    round_next_s = mode_i ? FIRST_ROUND_B : FIRST_ROUND_A;
                    fsm_next_s   = ST_RUN;
                end else begin
                    round_next_s = 4'd0;
                end
            end
            ST_RUN: begin
                state_next_s = perm_state_i;
                // >= rather than == so a corrupted counter still terminates
                // instead of running through 12..15.
                if (round_cnt_r >= LAST_ROUND) begin
                    fsm_next_s = ST_DONE;
                end else begin
                    round_next_s = round_cnt_r + 4'd1;
                end
            end
            ST_DONE: begin
                fsm_next_s   = ST_IDLE;
                round_next_s = 4'd0;
            end
            default: begin
                fsm_next_s   = ST_IDLE;
                round_next_s = 4'd0;
            end
        endcase
    end

    // State registers; ready/done are registered from the next-state decode
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            fsm_r       <= ST_IDLE;
            round_cnt_r <= 4'd0;
            state_r     <= 320'd0;
            ready_r     <= 1'b1;
            done_r      <= 1'b0;
        end else begin
            fsm_r       <= fsm_next_s;
            round_cnt_r <= round_next_s;
            state_r     <= state_next_s;
            ready_r     <= (fsm_next_s == ST_IDLE);
            done_r      <= (fsm_next_s == ST_DONE);
        end
    end

    assign ready_o      = ready_r;
    assign done_o       = done_r;
    assign round_o      = round_cnt_r;
    assign perm_state_o = state_r;
    assign state_o      = state_r;

endmodule

// File: tb/tb_permutation_controller.sv
module tb_permutation_controller;

    logic         clock_i = 1'b0;
    logic         reset_i;
    logic         start_i;
    logic         mode_i;
    logic [319:0] state_i;
    logic         ready_o;
    logic [3:0]   round_o;
    logic [319:0] perm_state_o;
    logic [319:0] perm_state_i;
    logic [319:0] state_o;
    logic         done_o;

    logic         dp_override;
    logic [319:0] dp_noise;
    logic [7:0]   rc_s;

    int total = 0;
    int bad   = 0;

    always #5 clock_i = ~clock_i;

    permutation_controller dut (
        .clock_i      (clock_i),
        .reset_i      (reset_i),
        .start_i      (start_i),
        .mode_i       (mode_i),
        .state_i      (state_i),
        .ready_o      (ready_o),
        .round_o      (round_o),
        .perm_state_o (perm_state_o),
        .perm_state_i (perm_state_i),
        .state_o      (state_o),
        .done_o       (done_o)
    );

    // Stub datapath: XOR 0x(f-r)r into word 2 only
    assign rc_s = {4'hf - round_o, round_o};
    assign perm_state_i = dp_override ? dp_noise
                        : (perm_state_o ^ {128'd0, 56'd0, rc_s, 128'd0});

    task automatic tick;
        @(posedge clock_i);
        #1;
    endtask

    task automatic check(input string tag, input logic [319:0] obs, input logic [319:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [319:0] rand_state();
        logic [319:0] r;
        for (int i = 0; i < 10; i++) r[32*i +: 32] = $urandom();
        return r;
    endfunction

    // Reference: n rounds ending at 11, net effect is word2 ^= XOR of constants
    function automatic logic [319:0] ref_perm(input logic [319:0] s, input logic m);
        int n;
        logic [7:0] acc;
        logic [319:0] res;
        n   = m ? 6 : 12;
        acc = 8'h00;
        for (int r = 12 - n; r <= 11; r++) acc ^= {4'(15 - r), 4'(r)};
        res = s;
        res[128 +: 64] = res[128 +: 64] ^ {56'd0, acc};
        return res;
    endfunction

    task automatic run_perm(input logic m, input logic [319:0] s, input bit poke);
        int n;
        logic [319:0] exp;
        n   = m ? 6 : 12;
        exp = ref_perm(s, m);
        check("ready_before", 320'(ready_o), 320'(1));
        start_i = 1'b1; mode_i = m; state_i = s;
        tick;
        start_i = 1'b0;
        check("accept_latch", state_o, s);
        for (int k = 0; k < n; k++) begin
            check("round_idx", 320'(round_o), 320'(12 - n + k));
            check("done_low", 320'(done_o), 320'(0));
            check("ready_low", 320'(ready_o), 320'(0));
            if (poke && k == 2) begin
                start_i = 1'b1; mode_i = ~m; state_i = ~s;
            end else begin
                start_i = 1'b0;
            end
            tick;
        end
        start_i = 1'b0;
        check("done_pulse", 320'(done_o), 320'(1));
        check("result", state_o, exp);
        check("ready_in_done", 320'(ready_o), 320'(0));
        tick;
        check("done_clear", 320'(done_o), 320'(0));
        check("ready_back", 320'(ready_o), 320'(1));
        check("result_hold", state_o, exp);
    endtask

    initial begin
        logic [319:0] s0;
        logic [319:0] s;
        logic [319:0] hold_exp;
        int done_times[$];
        bit found;
        bit seen_done;

        s0 = {64'hc8cddf37bcd0284a, 64'h4ed0ec0b98c529b7, 64'hbe263d4d7aecaaff,
              64'h8a55114d1cb6a9a2, 64'h80400c0600000000};
        dp_override = 1'b0; dp_noise = 320'd0;
        start_i = 1'b0; mode_i = 1'b0; state_i = 320'd0;
        reset_i = 1'b1;
        tick; tick;
        reset_i = 1'b0;
        check("rst_ready", 320'(ready_o), 320'(1));
        check("rst_done", 320'(done_o), 320'(0));
        check("rst_round", 320'(round_o), 320'(0));
        check("rst_state", state_o, 320'd0);
        check("rst_perm_state", perm_state_o, 320'd0);

        // Directed p^a and p^b
        run_perm(1'b0, s0, 1'b0);
        check("pa_word2", 320'(state_o[191:128]), 320'(64'hbe263d4d7aecaaff));
        run_perm(1'b1, s0, 1'b0);
        check("pb_word2", 320'(state_o[191:128]), 320'(64'hbe263d4d7aecaaee));

        // Busy rejection
        run_perm(1'b0, rand_state(), 1'b1);
        run_perm(1'b1, rand_state(), 1'b1);

        // Result hold with noisy inputs and no start
        s = rand_state();
        run_perm(1'b1, s, 1'b0);
        hold_exp = ref_perm(s, 1'b1);
        dp_override = 1'b1;
        for (int i = 0; i < 4; i++) begin
            dp_noise = rand_state();
            state_i  = rand_state();
            tick;
            check("hold_state", state_o, hold_exp);
            check("hold_done", 320'(done_o), 320'(0));
        end
        dp_override = 1'b0;

        // Randomized requests
        for (int i = 0; i < 6; i++) run_perm(1'($urandom_range(0, 1)), rand_state(), 1'b0);

        // Reset priority over simultaneous start
        reset_i = 1'b1; start_i = 1'b1; state_i = rand_state();
        tick;
        reset_i = 1'b0; start_i = 1'b0;
        check("prio_ready", 320'(ready_o), 320'(1));
        check("prio_round", 320'(round_o), 320'(0));
        check("prio_state", state_o, 320'd0);

        // Back-to-back with start held high
        s = rand_state();
        start_i = 1'b1; mode_i = 1'b0; state_i = s;
        for (int t = 1; t <= 40; t++) begin
            tick;
            if (done_o) begin
                done_times.push_back(t);
                check("b2b_result", state_o, ref_perm(s, 1'b0));
            end
        end
        start_i = 1'b0;
        check("b2b_count", 320'(done_times.size()), 320'(2));
        if (done_times.size() == 2) begin
            check("b2b_first", 320'(done_times[0]), 320'(13));
            check("b2b_spacing", 320'(done_times[1] - done_times[0]), 320'(14));
        end
        reset_i = 1'b1;
        tick;
        reset_i = 1'b0;

        // Abort at round 5 and restart with p^b
        start_i = 1'b1; mode_i = 1'b0; state_i = rand_state();
        tick;
        start_i = 1'b0;
        found = 1'b0;
        for (int t = 0; t < 20 && !found; t++) begin
            if (round_o == 4'd5) found = 1'b1;
            else tick;
        end
        check("abort_reach_r5", 320'(found), 320'(1));
        reset_i = 1'b1;
        tick; tick;
        reset_i = 1'b0;
        check("abort_ready", 320'(ready_o), 320'(1));
        check("abort_done", 320'(done_o), 320'(0));
        check("abort_round", 320'(round_o), 320'(0));
        check("abort_state", state_o, 320'd0);
        seen_done = 1'b0;
        for (int t = 0; t < 15; t++) begin
            tick;
            if (done_o) seen_done = 1'b1;
        end
        check("abort_no_done", 320'(seen_done), 320'(0));
        run_perm(1'b1, rand_state(), 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
